// File: rtl/ps2_mouse_packetizer_pkg.sv
// ps2_mouse_packetizer_pkg: PS/2 mouse command bytes, FSM encodings and event entry layout.
package ps2_mouse_packetizer_pkg;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK       = 8'hAA;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD_RATE = 3'd1;
  localparam logic [2:0] ST_CMD_VAL  = 3'd2;
  localparam logic [2:0] ST_CMD_EN   = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;
  localparam logic [2:0] ST_STREAM   = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;
  localparam int ENTRY_W = 67;
  typedef struct packed {
    logic [2:0]  btn;
    logic [31:0] dx;
    logic [31:0] dy;
  } mouse_entry_t;
  // Overflow saturates to the 9-bit extremes; otherwise sign-extend {sign,byte}.
  function automatic logic [31:0] ps2_delta(input logic sign, input logic ov, input logic [7:0] b);
    return ov ? (sign ? 32'hFFFF_FF00 : 32'd255) : {{24{sign}}, b};
  endfunction
endpackage

// File: rtl/mouse_event_fifo.sv
// mouse_event_fifo: first-word-fall-through FIFO with occupancy count and overflow drop pulse.
module mouse_event_fifo #(
  parameter int W     = 67,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic                   drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          drop_q, full, pop_ok, push_ok;
  assign full    = cnt_q == CW'(DEPTH);
  assign pop_ok  = pop_i && cnt_q != '0;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push_i && (!full || pop_ok);
  assign data_o  = mem_q[rd_q];
  assign valid_o = cnt_q != '0;
  assign cnt_o   = cnt_q;
  assign drop_o  = drop_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      drop_q <= push_i && !push_ok;
    end
  end
endmodule

// File: rtl/ps2_mouse_packetizer.sv
// ps2_mouse_packetizer: runs the PS/2 mouse init handshake, frames 3-byte stream packets
// into signed deltas plus buttons, and queues them for the virtio side.
module ps2_mouse_packetizer
  import ps2_mouse_packetizer_pkg::*;
#(
  parameter logic [7:0]  SAMPLE_RATE = 8'd40,
  parameter int          DEPTH       = 16,
  parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000,
  parameter int          MAX_RETRY   = 3,
  parameter logic [19:0] BYTE_GAP    = 20'd1_000_000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_en,
  input  logic                   i_tx_busy,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_en,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [2:0]             o_btn,
  output logic [31:0]            o_dx,
  output logic [31:0]            o_dy,
  output logic [$clog2(DEPTH):0] o_cnt,
  output logic                   o_ready,
  output logic                   o_err,
  output logic                   o_drop
);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);
  logic [2:0]   state_q, state_d, cmd_q, cmd_d;
  logic [7:0]   retry_q, retry_d, tx_data_q, tx_data_d, x_q, x_d;
  logic [23:0]  timer_q, timer_d;
  logic [19:0]  gap_q, gap_d;
  logic [6:0]   hdr_q, hdr_d;
  logic [1:0]   idx_q, idx_d;
  logic         tx_en_q, tx_en_d, err_q, err_d, push, bat, ack;
  mouse_entry_t entry, head;
  assign bat = i_rx_en && i_rx_data == PS2_BAT_OK;
  assign ack = i_rx_en && i_rx_data == PS2_ACK;
  // hdr_q packs {Yov, Xov, Ysign, Xsign, M, R, L}; the always-one bit3 is not kept.
  assign entry = {hdr_q[2:0], ps2_delta(hdr_q[3], hdr_q[5], x_q), ps2_delta(hdr_q[4], hdr_q[6], i_rx_data)};
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    err_d     = err_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    hdr_d     = hdr_q;
    x_d       = x_q;
    push      = 1'b0;
    if (i_start || bat) begin
      state_d = ST_CMD_RATE;
      retry_d = '0;
      idx_d   = '0;
      gap_d   = '0;
      err_d   = err_q && !i_start;
    end else begin
      case (state_q)
        ST_CMD_RATE, ST_CMD_VAL, ST_CMD_EN: begin
          if (!i_tx_busy) begin
            tx_en_d   = 1'b1;
            tx_data_d = state_q == ST_CMD_RATE ? PS2_CMD_SET_RATE :
                        state_q == ST_CMD_VAL  ? SAMPLE_RATE : PS2_CMD_ENABLE;
            cmd_d     = state_q;
            timer_d   = '0;
            state_d   = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ack) begin
            state_d = cmd_q == ST_CMD_RATE ? ST_CMD_VAL :
                      cmd_q == ST_CMD_VAL  ? ST_CMD_EN : ST_STREAM;
            retry_d = '0;
          end else if (timer_q >= ACK_TIMEOUT - 24'd1) begin
            state_d = retry_q >= RETRY_MAX ? ST_ERROR : cmd_q;
            err_d   = err_q || retry_q >= RETRY_MAX;
            retry_d = retry_q >= RETRY_MAX ? retry_q : retry_q + 8'd1;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        ST_STREAM: begin
          if (i_rx_en) begin
            gap_d = '0;
            if (idx_q == 2'd0) begin
              hdr_d = i_rx_data[3] ? {i_rx_data[7:4], i_rx_data[2:0]} : hdr_q;
              idx_d = i_rx_data[3] ? 2'd1 : 2'd0;
            end else if (idx_q == 2'd1) begin
              x_d   = i_rx_data;
              idx_d = 2'd2;
            end else begin
              push  = 1'b1;
              idx_d = 2'd0;
            end
          end else if (idx_q != 2'd0) begin
            idx_d = gap_q >= BYTE_GAP - 20'd1 ? 2'd0 : idx_q;
            gap_d = gap_q >= BYTE_GAP - 20'd1 ? '0 : gap_q + 20'd1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cmd_q     <= ST_IDLE;
      retry_q   <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      hdr_q     <= '0;
      x_q       <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      hdr_q     <= hdr_d;
      x_q       <= x_d;
    end
  end
  mouse_event_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (i_pop),
    .data_o  (head),
    .valid_o (o_valid),
    .cnt_o   (o_cnt),
    .drop_o  (o_drop)
  );
  assign o_btn     = head.btn;
  assign o_dx      = head.dx;
  assign o_dy      = head.dy;
  assign o_tx_data = tx_data_q;
  assign o_tx_en   = tx_en_q;
  assign o_ready   = state_q == ST_STREAM;
  assign o_err     = err_q;
endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// tb_ps2_mouse_packetizer: random and directed PS/2 traffic against a queue-based
// reference model; a monitor pops expected entries whenever the FIFO head is consumed.
module tb_ps2_mouse_packetizer;
  localparam int          DEPTH  = 16;
  localparam logic [23:0] ACK_TO = 24'd300;
  localparam logic [19:0] GAP    = 20'd60;
  localparam logic [7:0]  RATE   = 8'd40;

  logic        CLK = 1'b0, RST = 1'b1, i_start = 1'b0, i_rx_en = 1'b0, i_tx_busy = 1'b0, i_pop = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic [7:0]  o_tx_data;
  logic        o_tx_en, o_valid, o_ready, o_err, o_drop;
  logic [2:0]  o_btn;
  logic [31:0] o_dx, o_dy;
  logic [4:0]  o_cnt;

  int tests = 0, fails = 0, drops_seen = 0, exp_drops = 0, cyc = 0;
  bit rnd_done = 1'b0;
  logic [66:0] exp_q[$];
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];

  ps2_mouse_packetizer #(
    .SAMPLE_RATE (RATE),
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TO),
    .MAX_RETRY   (3),
    .BYTE_GAP    (GAP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_start   (i_start),
    .i_rx_data (i_rx_data),
    .i_rx_en   (i_rx_en),
    .i_tx_busy (i_tx_busy),
    .o_tx_data (o_tx_data),
    .o_tx_en   (o_tx_en),
    .i_pop     (i_pop),
    .o_valid   (o_valid),
    .o_btn     (o_btn),
    .o_dx      (o_dx),
    .o_dy      (o_dy),
    .o_cnt     (o_cnt),
    .o_ready   (o_ready),
    .o_err     (o_err),
    .o_drop    (o_drop)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: transmit log, drop pulses, and scoreboard compare on every accepted pop.
  always @(negedge CLK) begin
    if (o_tx_en) begin
      tx_log.push_back(o_tx_data);
      tx_cyc.push_back(cyc);
    end
    if (o_drop) drops_seen++;
    if (i_pop && o_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_entry: got %h with empty scoreboard", {o_btn, o_dx, o_dy});
      end else chk("entry", {o_btn, o_dx, o_dy}, exp_q.pop_front());
    end
  end

  function automatic logic [66:0] model(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y);
    int dx, dy;
    dx = h[6] ? (h[4] ? -256 : 255) : int'(x) - (h[4] ? 256 : 0);
    dy = h[7] ? (h[5] ? -256 : 255) : int'(y) - (h[5] ? 256 : 0);
    return {h[2:0], 32'(dx), 32'(dy)};
  endfunction

  function automatic logic [7:0] rb(input logic [7:0] orm);
    logic [7:0] v;
    do v = 8'($urandom) | orm; while (v == 8'hAA);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop);
    i_rx_data = b;
    i_rx_en   = 1'b1;
    if (pop) i_pop = 1'b1;
    tick(1);
    i_rx_en = 1'b0;
    if (pop) i_pop = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y, input bit pop);
    send_byte(h, 1'b0);
    tick($urandom_range(0, 4));
    send_byte(x, 1'b0);
    tick($urandom_range(0, 4));
    if (exp_q.size() < DEPTH || pop) exp_q.push_back(model(h, x, y));
    else exp_drops++;
    send_byte(y, pop);
  endtask

  task automatic wait_tx(output logic [7:0] b, output int c);
    int n = 0;
    while (tx_log.size() == 0 && n < int'(ACK_TO) + 50) begin
      tick(1);
      n++;
    end
    if (tx_log.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL tx_timeout: no o_tx_en within %0d cycles", n);
      b = 8'h00;
      c = 0;
    end else begin
      b = tx_log.pop_front();
      c = tx_cyc.pop_front();
    end
  endtask

  task automatic do_init(input bit start);
    logic [7:0] b;
    logic [7:0] seq [3];
    int c;
    seq = '{8'hF3, RATE, 8'hF4};
    if (start) begin
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      wait_tx(b, c);
      chk($sformatf("init_tx%0d", k), 67'(b), 67'(seq[k]));
      tick(100);
      send_byte(8'hFA, 1'b0);
    end
    tick(3);
    chk("init_ready", 67'(o_ready), 67'd1);
    chk("init_no_extra_tx", 67'(tx_log.size()), 67'd0);
  endtask

  task automatic drain;
    int n = 0;
    i_pop = 1'b1;
    while (o_valid && n < 64) begin
      tick(1);
      n++;
    end
    i_pop = 1'b0;
    tick(1);
  endtask

  task automatic chk_rst(input string name);
    chk({name, "_ctl"}, 67'({o_valid, o_cnt, o_ready, o_err, o_drop, o_tx_en, o_tx_data}), 67'd0);
    chk({name, "_head"}, {o_btn, o_dx, o_dy}, 67'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int c, cp;
    tick(3);
    chk_rst("reset");
    RST = 1'b0;
    tick(2);
    // Init with the transmitter busy first: nothing may go out until it frees up.
    i_tx_busy = 1'b1;
    i_start   = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(10);
    chk("busy_hold", 67'(tx_log.size()), 67'd0);
    i_tx_busy = 1'b0;
    do_init(1'b0);
    chk("init_err", 67'(o_err), 67'd0);
    // Directed packets, discarded header, resync after a gap.
    send_pkt(8'h19, 8'h05, 8'hFE, 1'b0);
    chk("push_latency", 67'(o_valid), 67'd1);
    send_pkt(8'h08, 8'h05, 8'hFE, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(2);
    send_pkt(8'hC8, 8'h10, 8'h10, 1'b0);
    send_byte(8'h18, 1'b0);
    tick(int'(GAP) + 10);
    send_pkt(8'h28, 8'h81, 8'h7F, 1'b0);
    tick(2);
    chk("directed_cnt", 67'(o_cnt), 67'd4);
    drain;
    chk("directed_sb_empty", 67'(exp_q.size()), 67'd0);
    // Random traffic with concurrent random pops.
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            send_byte(8'($urandom) & 8'hF7, 1'b0);
            tick($urandom_range(0, 2));
          end
          send_pkt(rb(8'h08), rb(8'h00), rb(8'h00), 1'b0);
          tick($urandom_range(0, 3));
        end
        rnd_done = 1'b1;
      end
      begin
        int n = 0;
        while (!(rnd_done && exp_q.size() == 0 && !o_valid) && n < 3000) begin
          i_pop = 1'($urandom_range(0, 1));
          tick(1);
          n++;
        end
        i_pop = 1'b0;
      end
    join
    chk("rnd_sb_empty", 67'(exp_q.size()), 67'd0);
    // Fill past capacity, then push and pop together at full.
    for (int k = 0; k < 17; k++) send_pkt(rb(8'h08), rb(8'h00), rb(8'h00), 1'b0);
    tick(2);
    chk("full_cnt", 67'(o_cnt), 67'd16);
    chk("full_drop", 67'(drops_seen), 67'(exp_drops));
    send_pkt(rb(8'h08), rb(8'h00), rb(8'h00), 1'b1);
    tick(2);
    chk("full_pushpop_cnt", 67'(o_cnt), 67'd16);
    chk("full_pushpop_drop", 67'(drops_seen), 67'(exp_drops));
    drain;
    chk("drain_valid", 67'(o_valid), 67'd0);
    chk("drain_sb_empty", 67'(exp_q.size()), 67'd0);
    i_pop = 1'b1;
    tick(1);
    i_pop = 1'b0;
    tick(1);
    chk("underflow_cnt", 67'(o_cnt), 67'd0);
    // Retry exhaustion with one entry parked in the FIFO.
    send_pkt(rb(8'h08), rb(8'h00), rb(8'h00), 1'b0);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_tx(b, cp);
    chk("retry_tx0", 67'(b), 67'hF3);
    for (int k = 1; k < 4; k++) begin
      wait_tx(b, c);
      chk($sformatf("retry_tx%0d", k), 67'(b), 67'hF3);
      chk($sformatf("retry_gap%0d", k), 67'(c - cp >= int'(ACK_TO) && c - cp <= int'(ACK_TO) + 4), 67'd1);
      cp = c;
    end
    tick(int'(ACK_TO) + 20);
    chk("err_set", 67'(o_err), 67'd1);
    chk("err_not_ready", 67'(o_ready), 67'd0);
    chk("err_no_more_tx", 67'(tx_log.size()), 67'd0);
    send_byte(8'hAA, 1'b0);
    do_init(1'b0);
    chk("err_sticky_after_bat", 67'(o_err), 67'd1);
    do_init(1'b1);
    chk("err_cleared_by_start", 67'(o_err), 67'd0);
    chk("fifo_kept", 67'(o_cnt), 67'd1);
    drain;
    // Reset in the middle of a packet with a non-empty FIFO.
    send_pkt(rb(8'h08), rb(8'h00), rb(8'h00), 1'b0);
    send_byte(8'h08, 1'b0);
    tick(1);
    send_byte(8'h11, 1'b0);
    RST = 1'b1;
    #1;
    chk_rst("midpkt_reset");
    exp_q.delete();
    tx_log.delete();
    tx_cyc.delete();
    tick(2);
    RST = 1'b0;
    tick(1);
    do_init(1'b1);
    send_pkt(rb(8'h08), rb(8'h00), rb(8'h00), 1'b0);
    tick(2);
    chk("post_reset_cnt", 67'(o_cnt), 67'd1);
    drain;
    chk("post_reset_sb_empty", 67'(exp_q.size()), 67'd0);
    chk("drops_total", 67'(drops_seen), 67'(exp_drops));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_packetizer.md
Name: ps2_mouse_packetizer

Overview:
- Sits between the PS/2 line interface and the virtio mouse device.
- Runs the mouse init command sequence over the PS/2 transmit path: set sample rate, rate value, enable reporting.
- Frames the 3-byte PS/2 stream packets, converts each one to signed 32-bit deltas plus button bits, and buffers the results in a first-word-fall-through FIFO.
- The virtio side drains the FIFO with a one-cycle pop pulse.

Parameters:
- SAMPLE_RATE, 8'd40, value sent after the 0xF3 command.
- DEPTH, 16, FIFO entries; power of two.
- ACK_TIMEOUT, 24'd10_000_000, cycles to wait for 0xFA before a retry.
- MAX_RETRY, 3, resends per command before the error state.
- BYTE_GAP, 20'd1_000_000, idle cycles between bytes that force a packet resync.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous and active-high, applied to all flops
- i_start  in  1  pulse; (re)starts the init sequence
- i_rx_data  in  8  received PS/2 byte
- i_rx_en  in  1  one-cycle strobe; i_rx_data is valid
- i_tx_busy  in  1  PS/2 transmitter busy
- o_tx_data  out  8  byte to transmit
- o_tx_en  out  1  one-cycle transmit strobe
- i_pop  in  1  consume the FIFO head
- o_valid  out  1  FIFO not empty
- o_btn  out  3  head entry {mid,right,left}
- o_dx  out  32  head entry dx, signed
- o_dy  out  32  head entry dy, signed; PS/2 convention, positive is up
- o_cnt  out  $clog2(DEPTH)+1  FIFO occupancy
- o_ready  out  1  FSM is in STREAM
- o_err  out  1  sticky; init failed
- o_drop  out  1  one-cycle pulse; packet lost because the FIFO was full

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; byte index 0; all counters 0.
- FSM states: IDLE, CMD_RATE, CMD_VAL, CMD_EN, WAIT_ACK, STREAM, ERROR.
- IDLE: go to CMD_RATE on i_start.
- Any state: i_rx_en with byte 0xAA (device self-test) also goes to CMD_RATE and clears the retry count.
  - In STREAM this also sets the byte index to 0.
  - The FIFO is kept.
- CMD_x states: wait until i_tx_busy=0, then pulse o_tx_en for one cycle with o_tx_data = 0xF3, SAMPLE_RATE, or 0xF4 respectively. Record the return state and go to WAIT_ACK with the timer cleared.
- WAIT_ACK:
  - i_rx_en with 0xFA: go to the next command state, or to STREAM after 0xF4; clear the retry count.
  - Any other received byte is ignored.
  - Timer reaching ACK_TIMEOUT: increment the retry count and resend the same command.
  - Retry count reaching MAX_RETRY: go to ERROR and set o_err.
- ERROR: leave only on i_start or 0xAA. o_err clears on i_start.
- STREAM, packet framing:
  - Index 0: accept the byte as header only if bit3=1; otherwise discard it and stay at index 0.
  - Header fields latched: L=b0, R=b1, M=b2, Xsign=b4, Ysign=b5, Xov=b6, Yov=b7.
  - Index 1 captures X; index 2 captures Y and completes the packet.
  - Gap timer: counts cycles with no i_rx_en while index≠0; at BYTE_GAP, index returns to 0 and the partial packet is discarded.
- Delta arithmetic:
  - delta = sign-extension of the 9-bit {sign,byte} to 32 bits.
  - If the overflow bit is set: delta = +255 when sign=0, -256 when sign=1.
- Push timing: the entry {btn,dx,dy} is pushed in the cycle after the third byte's strobe, i.e. o_valid is seen 1 cycle after that strobe.
- FIFO:
  - Pop with o_valid=1 advances the head; the outputs show the new head next cycle.
  - Pop on an empty FIFO is ignored; o_cnt does not underflow.
  - Push when full is discarded and o_drop pulses, unless a pop occurs in the same cycle, in which case both happen and o_cnt is unchanged.
  - Simultaneous push and pop when not full: o_cnt is unchanged.
  - Head and tail pointers wrap modulo DEPTH.
- Reset mid-packet or mid-command: immediate return to the reset state; any in-flight o_tx_en is dropped.

Decomposition:
- Shared package/header holds:
  - command constants PS2_CMD_SET_RATE=8'hF3, PS2_CMD_ENABLE=8'hF4, PS2_ACK=8'hFA, PS2_BAT_OK=8'hAA
  - FSM state encodings
  - mouse entry width 67 = 3 + 32 + 32
- One sub-module is natural: mouse_event_fifo, a parameterised FWFT FIFO with push, pop, cnt and drop.

Test Plan:
- Init: i_start; answer each transmit with 0xFA after 100 cycles -> o_tx_data sequence F3, 28, F4, one o_tx_en each; o_ready=1; o_err=0.
- Retry: no ACK -> same byte resent every ACK_TIMEOUT cycles; after 3 resends o_err=1, FSM in ERROR; a later 0xAA -> F3 is sent again.
- Packet: bytes 0x19, 0x05, 0xFE -> o_btn=3'b001, o_dx=-251, o_dy=254.
  - The X field is sign-extended 9'h105 = -251, because 0x19 has bit4 set.
  - Second case: 0x08, 0x05, 0xFE -> o_dx=5, o_dy=254.
- Overflow and resync:
  - 0xC8, 0x10, 0x10 -> dx=+255, dy=+255.
  - Header 0x00 is discarded.
  - A gap longer than BYTE_GAP after byte 1 drops the partial packet; the next 3 bytes form a valid entry.
- FIFO: push 17 packets without popping -> o_cnt=16 and exactly one o_drop pulse.
  - Pop and push in the same cycle at full -> o_cnt stays 16.
  - Drain 16 pops -> entries in order, o_valid=0.
  - An extra pop -> o_cnt remains 0.
- Reset: assert RST after byte 1 of a packet -> all outputs 0 immediately; after release, a full packet produces exactly one correct entry.
